// File: rtl/ftdi_sync_ctrl.sv
// Controller for the FTDI 245-style synchronous-FIFO bus: arbitrates receive and
// transmit bursts, inserts bus turnaround, and buffers received words in a skid FIFO.
module ftdi_sync_ctrl #(
  parameter int DATA_W      = 8,
  parameter int MAX_BURST   = 64,
  parameter int SKID_DEPTH  = 4,
  parameter int TURN_CYCLES = 1,
  parameter int RR_MODE     = 1
) (
  input  logic              ftdi_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe,
  input  logic              rxf_n,
  input  logic              txe_n,
  output logic              oe_n,
  output logic              rd_n,
  output logic              wr_n,
  input  logic [DATA_W-1:0] tx_tdata,
  input  logic              tx_tvalid,
  output logic              tx_tready,
  output logic [DATA_W-1:0] rx_tdata,
  output logic              rx_tvalid,
  input  logic              rx_tready,
  output logic [31:0]       rx_words,
  output logic [31:0]       tx_words,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RX_OE = 3'd1,
    RX_RD = 3'd2,
    TX_WR = 3'd3,
    TURN  = 3'd4
  } state_t;

  localparam int AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [AW:0] SKID_FULL = (AW + 1)'(SKID_DEPTH);
  localparam logic [8:0]  MAX_B     = 9'(MAX_BURST);
  localparam logic [1:0]  TURN_LAST = 2'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

  state_t            state_q, state_d;
  logic [8:0]        burst_q, burst_d;
  logic [1:0]        turn_q, turn_d;
  logic              last_rx_q, last_rx_d;
  logic [31:0]       rx_words_q, tx_words_q;

  logic [DATA_W-1:0] skid_mem_q [SKID_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       skid_cnt_q;

  logic skid_full, rx_req, tx_req, rd_en, wr_en, push, pop, burst_lt;

  assign skid_full = (skid_cnt_q == SKID_FULL);
  assign burst_lt  = (burst_q < MAX_B);
  assign rx_req    = !rxf_n && !skid_full;
  assign tx_req    = !txe_n && tx_tvalid;

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    turn_d    = turn_q;
    last_rx_d = last_rx_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        // Round-robin: the direction opposite to the last burst wins a contention.
        if (rx_req && (!tx_req || RR_MODE == 0 || !last_rx_q)) begin
          state_d = RX_OE;
          burst_d = '0;
        end else if (tx_req) begin
          state_d = TX_WR;
          burst_d = '0;
        end
      end
      RX_OE: state_d = RX_RD;
      RX_RD: begin
        rd_en = !rxf_n && !skid_full && burst_lt;
        if (rd_en) begin
          burst_d = burst_q + 9'd1;
        end else begin
          last_rx_d = 1'b1;
          turn_d    = '0;
          state_d   = (TURN_CYCLES == 0) ? IDLE : TURN;
        end
      end
      TX_WR: begin
        wr_en = !txe_n && tx_tvalid && burst_lt;
        if (wr_en) begin
          burst_d = burst_q + 9'd1;
        end else begin
          last_rx_d = 1'b0;
          turn_d    = '0;
          state_d   = (TURN_CYCLES == 0) ? IDLE : TURN;
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) state_d = IDLE;
        else                     turn_d  = turn_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      turn_q    <= '0;
      last_rx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      turn_q    <= turn_d;
      last_rx_q <= last_rx_d;
    end
  end

  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      rx_words_q <= '0;
      tx_words_q <= '0;
    end else begin
      rx_words_q <= rx_words_q + 32'(rd_en);
      tx_words_q <= tx_words_q + 32'(wr_en);
    end
  end

  // Skid FIFO: a push and a pop on the same edge leave the occupancy unchanged.
  assign push = rd_en;
  assign pop  = rx_tvalid && rx_tready;

  always_ff @(posedge ftdi_clk) begin
    if (push) skid_mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      skid_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   skid_cnt_q <= skid_cnt_q + 1'b1;
        2'b01:   skid_cnt_q <= skid_cnt_q - 1'b1;
        default: skid_cnt_q <= skid_cnt_q;
      endcase
    end
  end

  // Strobes are decoded from the registered state so reset releases the bus at once.
  assign oe_n      = !(state_q == RX_OE || state_q == RX_RD);
  assign rd_n      = !rd_en;
  assign wr_n      = !wr_en;
  assign data_oe   = (state_q == TX_WR);
  assign data_o    = tx_tdata;
  assign tx_tready = wr_en;
  assign rx_tvalid = (skid_cnt_q != '0);
  assign rx_tdata  = skid_mem_q[rd_ptr_q];
  assign rx_words  = rx_words_q;
  assign tx_words  = tx_words_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ftdi_sync_ctrl.sv
// Directed bench for ftdi_sync_ctrl with a small FTDI device model on both directions.
module tb_ftdi_sync_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_i, data_o, tx_tdata, rx_tdata;
  logic          data_oe, rxf_n, txe_n, oe_n, rd_n, wr_n;
  logic          tx_tvalid, tx_tready, rx_tvalid, rx_tready;
  logic [31:0]   rx_words, tx_words;
  logic [2:0]    state_o;

  int tests = 0;
  int fails = 0;

  // Device model state: words offered on each side and how many have been taken.
  logic [DW-1:0] rx_src [256];
  logic [DW-1:0] tx_src [256];
  int            rx_idx = 0, tx_idx = 0;
  int            rx_avail = 0, tx_avail = 0;
  logic [DW-1:0] rx_got [$];
  logic [DW-1:0] tx_got [$];
  logic [DW-1:0] exp_q  [$];
  logic [1:0]    dir_log [$];
  logic          log_en = 1'b0;
  logic          prev_oe_n = 1'b1;

  always #5 clk = ~clk;

  ftdi_sync_ctrl #(
    .DATA_W(DW), .MAX_BURST(4), .SKID_DEPTH(4), .TURN_CYCLES(1), .RR_MODE(1)
  ) dut (
    .ftdi_clk(clk), .rst(rst),
    .data_i(data_i), .data_o(data_o), .data_oe(data_oe),
    .rxf_n(rxf_n), .txe_n(txe_n), .oe_n(oe_n), .rd_n(rd_n), .wr_n(wr_n),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .rx_words(rx_words), .tx_words(tx_words), .state_o(state_o)
  );

  assign rxf_n     = !(rx_idx < rx_avail);
  assign data_i    = rx_src[rx_idx % 256];
  assign tx_tvalid = (tx_idx < tx_avail);
  assign tx_tdata  = tx_src[tx_idx % 256];

  always @(posedge clk) begin
    if (rst) begin
      rx_idx <= 0;
      tx_idx <= 0;
    end else begin
      if (!rd_n) rx_idx <= rx_idx + 1;
      if (!wr_n) begin
        tx_idx <= tx_idx + 1;
        tx_got.push_back(data_o);
      end
      if (rx_tvalid && rx_tready) rx_got.push_back(rx_tdata);
      if (log_en) dir_log.push_back({!wr_n, !rd_n});
    end
  end

  // Bus ownership: never drive while OE is low, and OE must be high the cycle before.
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      assert (!(data_oe && (!oe_n || !prev_oe_n))) else begin
        fails++;
        $error("FAIL bus_safety: data_oe=%0b oe_n=%0b prev_oe_n=%0b expected no overlap",
               data_oe, oe_n, prev_oe_n);
      end
    end
    prev_oe_n <= oe_n;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rx_got.delete();
    tx_got.delete();
    rx_avail = 0;
    tx_avail = 0;
    rst = 1'b0;
  endtask

  initial begin : main
    logic        ok;
    int          first;
    logic [37:0] pat;

    for (int i = 0; i < 256; i++) begin
      rx_src[i] = 8'(i * 7 + 3);
      tx_src[i] = 8'(i ^ 8'h5A);
    end
    txe_n     = 1'b0;
    rx_tready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_oe_n", 64'(oe_n), 64'd1);
    chk("rst_rd_n", 64'(rd_n), 64'd1);
    chk("rst_wr_n", 64'(wr_n), 64'd1);
    chk("rst_data_oe", 64'(data_oe), 64'd0);
    chk("rst_rx_tvalid", 64'(rx_tvalid), 64'd0);
    chk("rst_tx_tready", 64'(tx_tready), 64'd0);
    chk("rst_rx_words", 64'(rx_words), 64'd0);
    chk("rst_tx_words", 64'(tx_words), 64'd0);
    chk("rst_state", 64'(state_o), 64'd0);

    // Receive burst of 10 words; OE falls one cycle ahead of RD
    rx_avail = 10;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (!oe_n) ok = 1'b1;
    end
    chk("rx_oe_timeout", 64'(ok), 64'd1);
    chk("rx_oe_cycle_rd_n", 64'(rd_n), 64'd1);
    @(negedge clk);
    chk("rx_rd_cycle_rd_n", 64'(rd_n), 64'd0);
    chk("rx_rd_cycle_oe_n", 64'(oe_n), 64'd0);
    for (int i = 0; i < 10; i++) exp_q.push_back(rx_src[i]);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (rx_got.size() == 10) ok = 1'b1;
    end
    chk("rx_burst_timeout", 64'(ok), 64'd1);
    for (int i = 0; i < 10 && i < rx_got.size(); i++) chk("rx_burst_data", 64'(rx_got[i]), 64'(exp_q[i]));
    exp_q.delete();
    chk("rx_burst_words", 64'(rx_words), 64'd10);

    // Receive backpressure: skid of 4 fills and RD stays high
    rx_tready = 1'b0;
    rx_avail  = 20;
    repeat (30) @(negedge clk);
    chk("bp_rx_words", 64'(rx_words), 64'd14);
    chk("bp_rd_n", 64'(rd_n), 64'd1);
    chk("bp_rx_tvalid", 64'(rx_tvalid), 64'd1);
    chk("bp_no_pop", 64'(rx_got.size()), 64'd10);
    rx_tready = 1'b1;
    for (int i = 10; i < 20; i++) exp_q.push_back(rx_src[i]);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (rx_got.size() >= 20) ok = 1'b1;
    end
    chk("bp_timeout", 64'(ok), 64'd1);
    repeat (10) @(negedge clk);
    chk("bp_no_dup", 64'(rx_got.size()), 64'd20);
    for (int i = 10; i < 20 && i < rx_got.size(); i++) chk("bp_data", 64'(rx_got[i]), 64'(exp_q[i - 10]));
    exp_q.delete();
    chk("bp_rx_words_final", 64'(rx_words), 64'd20);

    // Round-robin with both sides always ready: RX4, TX4, RX4 with turnaround gaps
    do_reset();
    dir_log.delete();
    log_en   = 1'b1;
    rx_avail = 100;
    tx_avail = 100;
    repeat (40) @(negedge clk);
    log_en = 1'b0;
    first = -1;
    for (int i = 0; i < dir_log.size(); i++) if (first < 0 && dir_log[i] != 2'b00) first = i;
    pat = '0;
    if (first >= 0 && first + 19 <= dir_log.size())
      for (int i = 0; i < 19; i++) pat = {pat[35:0], dir_log[first + i]};
    chk("rr_first_rx", 64'(first >= 0 ? dir_log[first] : 2'b00), 64'b01);
    chk("rr_pattern", 64'(pat), 64'(38'b01010101_000000_10101010_00000000_01010101));
    chk("rr_tx_data0", 64'(tx_got.size() > 0 ? tx_got[0] : 8'h00), 64'(tx_src[0]));

    // Transmit 100 words with txe_n rising after word 37
    do_reset();
    tx_avail = 100;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (tx_got.size() >= 37) ok = 1'b1;
    end
    txe_n = 1'b1;
    chk("tx_stop_timeout", 64'(ok), 64'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("tx_stop_tready", 64'(tx_tready), 64'd0);
    end
    chk("tx_stop_count", 64'(tx_got.size()), 64'd37);
    chk("tx_stop_words", 64'(tx_words), 64'd37);
    txe_n = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 600 && !ok; c++) begin
      @(negedge clk);
      if (tx_got.size() >= 100) ok = 1'b1;
    end
    chk("tx_resume_timeout", 64'(ok), 64'd1);
    repeat (5) @(negedge clk);
    chk("tx_total_count", 64'(tx_got.size()), 64'd100);
    for (int i = 0; i < 100 && i < tx_got.size(); i++) chk("tx_data", 64'(tx_got[i]), 64'(tx_src[i]));
    chk("tx_total_words", 64'(tx_words), 64'd100);

    // Asynchronous reset in the middle of an RX_RD burst
    rx_avail = 8;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (state_o == 3'd2 && !rd_n) ok = 1'b1;
    end
    chk("mid_rst_reach_rd", 64'(ok), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rd_n", 64'(rd_n), 64'd1);
    chk("mid_rst_oe_n", 64'(oe_n), 64'd1);
    chk("mid_rst_wr_n", 64'(wr_n), 64'd1);
    chk("mid_rst_rx_tvalid", 64'(rx_tvalid), 64'd0);
    chk("mid_rst_rx_words", 64'(rx_words), 64'd0);
    chk("mid_rst_tx_words", 64'(tx_words), 64'd0);
    chk("mid_rst_state", 64'(state_o), 64'd0);

    // Receive counter wraps through zero
    do_reset();
    @(negedge clk);
    force dut.rx_words_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.rx_words_q;
    @(negedge clk);
    chk("wrap_preset", 64'(rx_words), 64'hFFFF_FFFE);
    rx_avail = 3;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (rx_got.size() >= 3) ok = 1'b1;
    end
    chk("wrap_timeout", 64'(ok), 64'd1);
    repeat (5) @(negedge clk);
    chk("wrap_rx_words", 64'(rx_words), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
